// File: rtl/sync_tff_updown_counter_pkg.sv
// Shared definitions for the T-flip-flop up/down counter: direction encodings
// and a constant-evaluable ceiling log2 for derived widths.
package sync_tff_updown_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_tff_updown_counter_tff_cell.sv
// Single T flip-flop: toggles on t at the rising edge, asynchronously forced
// to rst_val while reset is low.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  logic state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= rst_val;
    end else if (t) begin
      state_q <= ~state_q;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/sync_tff_updown_counter.sv
// Modulo-N up/down counter with clamped parallel load, built from T flip-flops
// whose toggle inputs are the XOR of current and desired next count.
module sync_tff_updown_counter
  import sync_tff_updown_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VALUE);

  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("sync_tff_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("sync_tff_updown_counter: RESET_VALUE must be below MODULUS");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] t_bits;
  logic             at_max;
  logic             at_zero;
  logic             wrap_d;
  logic             wrap_q;

  assign at_max  = (count_q == MAX_Q);
  assign at_zero = (count_q == '0);

  // Explicit boundary compares keep non-power-of-2 moduli and natural
  // overflow on power-of-2 moduli on one code path.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = ({1'b0, d} < MOD_EXT) ? d : MAX_Q;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        count_d = at_max ? '0 : count_q + WIDTH'(1);
        wrap_d  = at_max;
      end else begin
        count_d = at_zero ? MAX_Q : count_q - WIDTH'(1);
        wrap_d  = at_zero;
      end
    end
  end

  assign t_bits = count_q ^ count_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    tff_cell u_tff (
      .clk     (clk),
      .reset   (reset),
      .t       (t_bits[gi]),
      .rst_val (RST_Q[gi]),
      .q       (count_q[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign tc   = (up_dn == DIR_DN) ? at_zero : at_max;
  assign co   = tc & en & ~load;
  assign q    = count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_tff_updown_counter.sv
// Directed bench: a vector table on a modulo-10 counter, a full down sweep on
// a modulo-16 counter, asynchronous reset corners, and an 8-bit cascade.
module tb_sync_tff_updown_counter;

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       co;
    logic       wr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // modulo-10 instance
  logic       r10 = 1'b0, en10 = 1'b0, up10 = 1'b1, ld10 = 1'b0;
  logic [3:0] d10 = '0, q10;
  logic       tc10, co10, wr10;

  // modulo-16 instance
  logic       r16 = 1'b0, en16 = 1'b0, up16 = 1'b0, ld16 = 1'b0;
  logic [3:0] d16 = '0, q16;
  logic       tc16, co16, wr16;

  // cascade pair
  logic       rc = 1'b0, cen = 1'b0, cld = 1'b0;
  logic [3:0] cdl = '0, cdh = '0, lq, hq;
  logic       ltc, lco, lwr, htc, hco, hwr;

  sync_tff_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut10 (
    .clk(clk), .reset(r10), .en(en10), .up_dn(up10), .load(ld10), .d(d10),
    .q(q10), .tc(tc10), .co(co10), .wrap(wr10));

  sync_tff_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut16 (
    .clk(clk), .reset(r16), .en(en16), .up_dn(up16), .load(ld16), .d(d16),
    .q(q16), .tc(tc16), .co(co16), .wrap(wr16));

  sync_tff_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) u_lo (
    .clk(clk), .reset(rc), .en(cen), .up_dn(1'b1), .load(cld), .d(cdl),
    .q(lq), .tc(ltc), .co(lco), .wrap(lwr));

  sync_tff_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) u_hi (
    .clk(clk), .reset(rc), .en(lco), .up_dn(1'b1), .load(cld), .d(cdh),
    .q(hq), .tc(htc), .co(hco), .wrap(hwr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic up, input logic ld,
                              input logic [3:0] d, input logic [3:0] q,
                              input logic tc, input logic co, input logic wr);
    vec_t v;
    v.en = en; v.up = up; v.ld = ld; v.d = d;
    v.q = q; v.tc = tc; v.co = co; v.wr = wr;
    return v;
  endfunction

  vec_t vecs[$];
  int   hi_wraps;

  initial begin
    // count up 0..9 then wrap
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 1, 0, 0, 4'(i), 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'd9, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 4'd1, 0, 0, 0));
    // down from 9 with two held edges
    vecs.push_back(mk(0, 0, 1, 4'd9, 4'd9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd9, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'd8, 0, 0, 0));
    // down wrap 0 -> 9
    vecs.push_back(mk(0, 0, 1, 4'd0, 4'd0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'd9, 0, 0, 1));
    // load corners
    vecs.push_back(mk(1, 1, 1, 4'd5, 4'd5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'd12, 4'd9, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'd9, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'd9, 4'd9, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'd10, 4'd9, 1, 0, 0));
    // direction change at a boundary: no wrap
    vecs.push_back(mk(0, 0, 1, 4'd0, 4'd0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'd1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'd15, 4'd9, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 4'd3, 4'd3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd3, 0, 0, 0));

    // reset values with no clock edge yet
    #2;
    check("rst10_q", 32'(q10), 32'd0);
    check("rst10_wrap", 32'(wr10), 32'd0);
    check("rst16_q", 32'(q16), 32'd0);
    check("rst16_wrap", 32'(wr16), 32'd0);
    en10 = 1'b1; en16 = 1'b1;
    tick(); tick();
    check("rst10_held_q", 32'(q10), 32'd0);
    check("rst16_held_q", 32'(q16), 32'd0);

    // modulo-16 down sweep from reset
    r16 = 1'b1;
    check("m16_tc_at0", 32'(tc16), 32'd1);
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] eq;
      eq = 4'(15 - i);
      tick();
      check($sformatf("m16_q[%0d]", i), 32'(q16), 32'(eq));
      check($sformatf("m16_wrap[%0d]", i), 32'(wr16), 32'((i == 0) || (i == 16)));
      check($sformatf("m16_tc[%0d]", i), 32'(tc16), 32'(eq == 4'd0));
    end
    en16 = 1'b0;

    // modulo-10 vector table
    en10 = 1'b0;
    r10  = 1'b1;
    foreach (vecs[i]) begin
      en10 = vecs[i].en; up10 = vecs[i].up; ld10 = vecs[i].ld; d10 = vecs[i].d;
      tick();
      check($sformatf("v%0d_q", i), 32'(q10), 32'(vecs[i].q));
      check($sformatf("v%0d_tc", i), 32'(tc10), 32'(vecs[i].tc));
      check($sformatf("v%0d_co", i), 32'(co10), 32'(vecs[i].co));
      check($sformatf("v%0d_wrap", i), 32'(wr10), 32'(vecs[i].wr));
    end

    // async reset mid-cycle while counting up at 6
    en10 = 1'b0; up10 = 1'b1; ld10 = 1'b1; d10 = 4'd5;
    tick();
    ld10 = 1'b0; en10 = 1'b1;
    tick();
    check("pre_rst_q", 32'(q10), 32'd6);
    #2 r10 = 1'b0;
    #1;
    check("async_rst_q", 32'(q10), 32'd0);
    check("async_rst_wrap", 32'(wr10), 32'd0);
    tick(); tick();
    check("rst_hold_q", 32'(q10), 32'd0);

    // async reset clears a live wrap pulse
    r10 = 1'b1; en10 = 1'b0; ld10 = 1'b1; d10 = 4'd9;
    tick();
    ld10 = 1'b0; en10 = 1'b1;
    tick();
    check("wrap_live", 32'(wr10), 32'd1);
    #2 r10 = 1'b0;
    #1;
    check("wrap_async_clr", 32'(wr10), 32'd0);
    r10 = 1'b1; en10 = 1'b0;

    // cascade: 8-bit up count across nibble and full-range boundaries
    rc = 1'b1; cld = 1'b1; cdh = 4'h0; cdl = 4'hF;
    tick();
    check("cas_load_0f", 32'({hq, lq}), 32'h0F);
    cld = 1'b0; cen = 1'b1;
    tick();
    check("cas_0f_to_10", 32'({hq, lq}), 32'h10);
    check("cas_10_hwrap", 32'(hwr), 32'd0);
    cen = 1'b0; cld = 1'b1; cdh = 4'hF; cdl = 4'hE;
    tick();
    check("cas_load_fe", 32'({hq, lq}), 32'hFE);
    cld = 1'b0; cen = 1'b1;
    hi_wraps = 0;
    tick();
    check("cas_ff", 32'({hq, lq}), 32'hFF);
    hi_wraps += int'(hwr);
    tick();
    check("cas_ff_to_00", 32'({hq, lq}), 32'h00);
    check("cas_00_hwrap", 32'(hwr), 32'd1);
    hi_wraps += int'(hwr);
    tick();
    check("cas_01", 32'({hq, lq}), 32'h01);
    check("cas_01_hwrap", 32'(hwr), 32'd0);
    hi_wraps += int'(hwr);
    check("cas_hwrap_count", 32'(hi_wraps), 32'd1);
    cen = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
